// File: rtl/serial_neg_pkg.sv
// Shared definitions for the bit-serial negate sequencer: FSM encoding,
// default word width and counter sizing.
package serial_neg_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit counter must index 0..width-1; a 2-bit word still needs one bit.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/twos_comp_bit.sv
// Serial two's-complement cell: passes bits through until the first 1 has
// been seen, then inverts every later bit when negating.
module twos_comp_bit (
  input  logic t_clk,
  input  logic r_n,
  input  logic clr,
  input  logic en,
  input  logic neg,
  input  logic b,
  output logic y
);

  logic seen_one;

  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      seen_one <= 1'b0;
    end else if (clr) begin
      seen_one <= 1'b0;
    end else if (en) begin
      seen_one <= seen_one | b;
    end
  end

  assign y = neg ? (b ^ seen_one) : b;

endmodule

// File: rtl/serial_negate_ctrl.sv
// Sequencer that shifts a parallel word LSB-first through the serial
// complementer cell and reassembles the result behind valid/ready handshakes.
import serial_neg_pkg::*;

module serial_negate_ctrl #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             t_clk,
  input  logic             r_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  localparam int            CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic [1:0]    ST_IDLE  = 2'(IDLE);
  localparam logic [1:0]    ST_SHIFT = 2'(SHIFT);
  localparam logic [1:0]    ST_DONE  = 2'(DONE);

  logic [1:0]       state;
  logic             armed;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] result;
  logic [CW-1:0]    count;
  logic             neg;
  logic             ovf;
  logic             y;
  logic             accept;
  logic             done_hs;
  logic             shift_en;
  logic             last_bit;

  // armed keeps in_ready low until the first edge after reset release.
  assign in_ready  = armed & (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign out_data  = result;
  assign out_ovf   = ovf;

  assign accept   = in_valid & in_ready;
  assign done_hs  = out_valid & out_ready;
  assign shift_en = (state == ST_SHIFT);
  assign last_bit = shift_en && (count == LAST);

  twos_comp_bit u_cell (
    .t_clk (t_clk),
    .r_n   (r_n),
    .clr   (accept),
    .en    (shift_en),
    .neg   (neg),
    .b     (sr[0]),
    .y     (y)
  );

  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      state  <= ST_IDLE;
      armed  <= 1'b0;
      sr     <= '0;
      result <= '0;
      count  <= '0;
      neg    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sr     <= in_data;
            neg    <= in_neg;
            count  <= '0;
            result <= '0;
            ovf    <= 1'b0;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          result <= {y, result[WIDTH-1:1]};
          sr     <= {1'b0, sr[WIDTH-1:1]};
          count  <= count + 1'b1;
          if (last_bit) begin
            // MSB set with y still 1 means no lower bit was set: most-negative value.
            ovf   <= neg & sr[0] & y;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (done_hs) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_negate_ctrl.sv
// Scoreboard bench for serial_negate_ctrl at WIDTH = 8 with directed vectors.
module tb_serial_negate_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       in_neg = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_ovf;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] exp_q[$];

  serial_negate_ctrl #(.WIDTH(8)) dut (
    .t_clk     (clk),
    .r_n       (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_neg    (in_neg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expected {ovf,data} whenever the DUT completes an output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else if (out_ready) begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("result", {23'd0, out_ovf, out_data}, {23'd0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after a posedge; returns #1 after the accept edge.
  task automatic send(input logic [7:0] d, input logic n, input logic [7:0] ed, input logic eovf);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_neg   = n;
    exp_q.push_back({eovf, ed});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (!(exp_q.size() == 0 && in_ready) && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_outputs", {27'd0, in_ready, out_valid, out_ovf, busy, |out_data}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("ready_low_before_edge", 32'(in_ready), 32'd0);
    tick();
    chk("ready_after_release", 32'(in_ready), 32'd1);

    // Negate 0x05 with latency and single-cycle out_valid
    send(8'h05, 1'b1, 8'hFB, 1'b0);
    chk("busy_after_accept", 32'(busy), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("latency_k%0d", k), 32'(out_valid), 32'(k == 8));
    end
    tick();
    chk("out_valid_one_cycle", 32'(out_valid), 32'd0);
    chk("ready_after_hs", 32'(in_ready), 32'd1);

    send(8'hA6, 1'b0, 8'hA6, 1'b0); drain();
    send(8'h00, 1'b1, 8'h00, 1'b0); drain();
    send(8'h01, 1'b1, 8'hFF, 1'b0); drain();
    send(8'h80, 1'b1, 8'h80, 1'b1); drain();
    send(8'h81, 1'b1, 8'h7F, 1'b0); drain();
    send(8'h80, 1'b0, 8'h80, 1'b0); drain();

    // Backpressure with a second word waiting
    out_ready = 1'b0;
    send(8'h05, 1'b1, 8'hFB, 1'b0);
    for (int k = 0; k < 8; k++) tick();
    chk("bp_valid_rise", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h81;
    in_neg   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid_hold", 32'(out_valid), 32'd1);
      chk("bp_data_hold", 32'(out_data), 32'hFB);
      chk("bp_ready_low", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_hs_valid_low", 32'(out_valid), 32'd0);
    chk("bp_hs_ready_high", 32'(in_ready), 32'd1);
    exp_q.push_back({1'b0, 8'h7F});
    tick();
    chk("bp_second_accept", 32'(busy), 32'd1);
    in_valid = 1'b0;
    drain();

    // Input changes after accept are ignored
    send(8'h05, 1'b1, 8'hFB, 1'b0);
    in_data = 8'hFF;
    in_neg  = 1'b0;
    drain();

    // Reset during the third SHIFT cycle
    send(8'h07, 1'b1, 8'hF9, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {27'd0, in_ready, out_valid, out_ovf, busy, |out_data}, 32'd0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("abort_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end
    send(8'h03, 1'b1, 8'hFD, 1'b0);
    drain();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_negate_ctrl.md
# serial_negate_ctrl

Sequencer for the bit-serial two's-complement datapath. It accepts a parallel word over a valid/ready handshake and shifts it LSB-first through a serial complementer cell, one bit per clock. It reassembles the serial result into a parallel word and returns it over a second valid/ready handshake, with an overflow flag. It sits between a parallel requester and the serial complementer cell, which it owns and sequences.

## Interface
Parameters:
- WIDTH, 8, word width in bits; legal range WIDTH >= 2.

Ports:
- t_clk  input  1  sole clock; all state updates on the rising edge.
- r_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  requester presents a word.
- in_ready  output  1  block can accept; high only in IDLE with r_n high.
- in_data  input  WIDTH  operand; sampled only on the accept edge.
- in_neg  input  1  1 = negate (two's complement), 0 = pass through; sampled with in_data.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  result word.
- out_ovf  output  1  set when a negate is requested for the most-negative value (1 followed by WIDTH-1 zeros).
- busy  output  1  high in SHIFT or DONE.

## Operation
- The state machine has three states: IDLE, SHIFT and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: load shift register <= in_data and latch neg <= in_neg.
  - Clear the seen_one flag, the bit counter and the result register; go to SHIFT.
- SHIFT: each cycle, take b = sr[0].
  - y = neg ? (b ^ seen_one) : b.
  - seen_one <= seen_one | b.
  - result <= {y, result[WIDTH-1:1]}; sr shifts right; count++.
  - When count == WIDTH-1 (the last bit is processed this cycle), go to DONE.
- Overflow:
  - Capture, before the MSB is processed, whether seen_one is 0 (all lower bits zero).
  - out_ovf = neg && lower_zero && msb.
- DONE:
  - out_valid = 1.
  - out_data and out_ovf hold stable until out_valid && out_ready; then go to IDLE.
- Arithmetic:
  - The result is modulo 2^WIDTH; no width growth.
  - Negating 0 gives 0 with ovf 0.
  - Negating the most-negative value gives the same value with ovf 1.
- in_data and in_neg changes after the accept edge are ignored.
- out_ready is ignored outside DONE.
- in_valid is ignored outside IDLE; no queuing.

## Timing
- Reset (r_n low, asynchronous):
  - state = IDLE.
  - in_ready = 0, out_valid = 0, out_data = 0, out_ovf = 0, busy = 0.
  - Shift register, counter and seen_one are cleared.
- in_ready rises in the first cycle after r_n deasserts.
- Accept at edge E0. SHIFT occupies edges E1..E_WIDTH; out_valid is high after E_WIDTH (latency WIDTH cycles).
- With out_ready already high, the output handshake completes at E_WIDTH+1 and in_ready is high after it.
- The earliest next accept is E_WIDTH+2; the sustained period is WIDTH+2 cycles.
- in_ready and out_valid are decoded from registered state only; there is no combinational path from in_valid or out_ready.
- Reset mid-SHIFT or mid-DONE abandons the operation: no result is emitted and outputs return to reset values immediately.
- If in_valid and out_ready are both asserted in DONE, only the output handshake completes that cycle. The input is accepted at the next edge in IDLE.

## Structure
- Package serial_neg_pkg:
  - State enum (IDLE, SHIFT, DONE).
  - Default WIDTH constant.
  - Counter-width function, clog2(WIDTH).
- Sub-module twos_comp_bit is the serial complementer cell. Ports: t_clk, r_n, clr, en, neg, b, y.
  - It holds the seen_one flop internally.
  - y = neg ? b ^ seen_one : b.
  - seen_one updates on en; clr has priority over en.
- The top level holds the FSM, bit counter, input shift register, result shift register and overflow capture.

## Test plan
WIDTH = 8 for all scenarios.
- Negate 8'h05 (in_neg=1, out_ready=1) -> out_data 8'hFB, out_ovf 0; out_valid first high exactly 8 cycles after the accept edge and for 1 cycle.
- Pass 8'hA6 (in_neg=0) -> 8'hA6, ovf 0. Negate 8'h00 -> 8'h00, ovf 0. Negate 8'h01 -> 8'hFF.
- Negate 8'h80 -> out_data 8'h80, out_ovf 1. Negate 8'h81 -> 8'h7F, ovf 0.
- Backpressure: hold out_ready low 5 cycles in DONE -> out_valid and out_data remain stable, in_ready stays 0. With in_valid held high, the second word is accepted exactly 1 cycle after the output handshake.
- Change in_data from 8'h05 to 8'hFF one cycle after accept -> result still 8'hFB.
- Pull r_n low during the 3rd SHIFT cycle -> all outputs 0 immediately. After release, in_ready = 1, no out_valid appears, and a fresh negate of 8'h03 returns 8'hFD.
